// File: rtl/uart_frame_tx.sv
// rtl/uart_frame_tx.sv - frames buffer bytes as AA 55 LEN payload [CSUM] for a byte-level UART transmitter
// Optional trailing checksum byte is built when FRAME_CSUM_EN is defined.
module uart_frame_tx #(
    parameter int         ADDR_W  = 8,
    parameter logic [7:0] HDR0    = 8'hAA,
    parameter logic [7:0] HDR1    = 8'h55,
    parameter int         GAP_CYC = 4,
    parameter int         TMO_CYC = 100000
) (
    input  logic              sys_clk,
    input  logic              sys_rst_n,
    input  logic              start,
    input  logic [7:0]        frame_len,
    input  logic [ADDR_W-1:0] base_addr,
    output logic              busy,
    output logic              done,
    output logic              err,
    output logic              rd_en,
    output logic [ADDR_W-1:0] rd_addr,
    input  logic [7:0]        rd_data,
    output logic              tx_en,
    output logic [7:0]        tx_data,
    input  logic              tx_done
);
    localparam int GW = (GAP_CYC > 1) ? $clog2(GAP_CYC) : 1;

    typedef enum logic [2:0] {S_IDLE, S_FETCH, S_LOAD, S_SEND, S_GAP} state_t;
    typedef enum logic [2:0] {P_H0, P_H1, P_LEN, P_PAY, P_CSUM} phase_t;

    state_t            state, state_nxt;
    phase_t            phase, phase_nxt;
    logic [7:0]        len_q, idx, idx_nxt;
    logic [ADDR_W-1:0] base_q;
    logic [GW-1:0]     gap_cnt;
    logic [19:0]       tmo_cnt;
    logic              accept, gap_last, tmo_hit, finish, abort;
    logic [7:0]        load_byte;

    // busy stays high through the done cycle, so a start coinciding with done is dropped
    assign accept   = (state == S_IDLE) && start && !busy;
    assign gap_last = (gap_cnt == GW'(GAP_CYC - 1));
    assign tmo_hit  = (tmo_cnt == 20'(TMO_CYC - 1));

`ifdef FRAME_CSUM_EN
    logic [7:0] csum;

    always_ff @(posedge sys_clk or negedge sys_rst_n) begin
        if (!sys_rst_n) begin
            csum <= '0;
        end else if (accept) begin
            csum <= '0;
        end else if (state == S_LOAD && phase == P_LEN) begin
            csum <= len_q;
        end else if (state == S_LOAD && phase == P_PAY) begin
            csum <= csum + rd_data;
        end
    end
`endif

    always_comb begin
        load_byte = 8'h00;
        case (phase)
            P_H0:    load_byte = HDR0;
            P_H1:    load_byte = HDR1;
            P_LEN:   load_byte = len_q;
            P_PAY:   load_byte = rd_data;
`ifdef FRAME_CSUM_EN
            P_CSUM:  load_byte = csum;
`endif
            default: load_byte = 8'h00;
        endcase
    end

    always_ff @(posedge sys_clk or negedge sys_rst_n) begin
        if (!sys_rst_n) begin
            state <= S_IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        phase_nxt = phase;
        idx_nxt   = idx;
        finish    = 1'b0;
        abort     = 1'b0;
        rd_en     = 1'b0;
        rd_addr   = '0;
        case (state)
            S_IDLE: begin
                if (accept) begin
                    state_nxt = S_LOAD;
                    phase_nxt = P_H0;
                    idx_nxt   = 8'd0;
                end
            end
            S_FETCH: begin
                rd_en     = 1'b1;
                rd_addr   = base_q + ADDR_W'(idx);
                state_nxt = S_LOAD;
            end
            S_LOAD: state_nxt = S_SEND;
            S_SEND: begin
                if (tx_done) begin
                    state_nxt = S_GAP;
                end else if (tmo_hit) begin
                    abort     = 1'b1;
                    state_nxt = S_IDLE;
                end
            end
            S_GAP: begin
                if (gap_last) begin
                    case (phase)
                        P_H0: begin
                            phase_nxt = P_H1;
                            state_nxt = S_LOAD;
                        end
                        P_H1: begin
                            phase_nxt = P_LEN;
                            state_nxt = S_LOAD;
                        end
                        P_LEN, P_PAY: begin
                            if ((phase == P_LEN && len_q != 8'd0) ||
                                (phase == P_PAY && idx != len_q - 8'd1)) begin
                                idx_nxt   = (phase == P_LEN) ? 8'd0 : idx + 8'd1;
                                phase_nxt = P_PAY;
                                state_nxt = S_FETCH;
                            end else begin
`ifdef FRAME_CSUM_EN
                                phase_nxt = P_CSUM;
                                state_nxt = S_LOAD;
`else
                                finish    = 1'b1;
                                state_nxt = S_IDLE;
`endif
                            end
                        end
                        default: begin
                            finish    = 1'b1;
                            state_nxt = S_IDLE;
                        end
                    endcase
                end
            end
            default: state_nxt = S_IDLE;
        endcase
    end

    always_ff @(posedge sys_clk or negedge sys_rst_n) begin
        if (!sys_rst_n) begin
            phase   <= P_H0;
            idx     <= '0;
            len_q   <= '0;
            base_q  <= '0;
            gap_cnt <= '0;
            tmo_cnt <= '0;
            busy    <= 1'b0;
            done    <= 1'b0;
            err     <= 1'b0;
            tx_en   <= 1'b0;
            tx_data <= '0;
        end else begin
            phase <= phase_nxt;
            idx   <= idx_nxt;
            if (accept) begin
                len_q  <= frame_len;
                base_q <= base_addr;
            end
            gap_cnt <= (state == S_GAP && !gap_last) ? gap_cnt + GW'(1) : '0;
            tmo_cnt <= (state == S_SEND && !tx_done) ? tmo_cnt + 20'd1 : '0;
            // tx_en rises one cycle after tx_data settles and drops right after tx_done
            tx_en   <= (state == S_SEND) && !tx_done && !tmo_hit;
            done    <= finish || abort;
            err     <= abort;
            busy    <= (state_nxt != S_IDLE) || finish || abort;
            if (state == S_LOAD) begin
                tx_data <= load_byte;
            end
        end
    end
endmodule

// File: tb/tb_uart_frame_tx.sv
// tb/tb_uart_frame_tx.sv - directed self-checking bench for uart_frame_tx
module tb_uart_frame_tx;
    localparam int TMO = 300;
    localparam int GAP = 4;
    localparam int DLY = 40;

    logic       sys_clk = 1'b0;
    logic       sys_rst_n = 1'b0;
    logic       start = 1'b0;
    logic [7:0] frame_len = 8'h00;
    logic [7:0] base_addr = 8'h00;
    logic [7:0] rd_data = 8'h00;
    logic       tx_done = 1'b0;
    logic       busy, done, err, rd_en, tx_en;
    logic [7:0] rd_addr, tx_data;

    uart_frame_tx #(.ADDR_W(8), .GAP_CYC(GAP), .TMO_CYC(TMO)) dut (
        .sys_clk   (sys_clk),
        .sys_rst_n (sys_rst_n),
        .start     (start),
        .frame_len (frame_len),
        .base_addr (base_addr),
        .busy      (busy),
        .done      (done),
        .err       (err),
        .rd_en     (rd_en),
        .rd_addr   (rd_addr),
        .rd_data   (rd_data),
        .tx_en     (tx_en),
        .tx_data   (tx_data),
        .tx_done   (tx_done)
    );

    always #5 sys_clk = ~sys_clk;

    logic [7:0] mem [256];
    always @(posedge sys_clk) if (rd_en) rd_data <= mem[rd_addr];

    logic [7:0] byte_q[$];
    logic [7:0] addr_q[$];
    logic [7:0] exp_q[$];
    int         done_cnt = 0, unstable = 0, min_low = 1000, low_run = 1000;
    int         countdown = 0, withhold_idx = -1;
    int         cyc = 0, cyc_txdone = 0, cyc_done = 0, cyc_rise = 0;
    logic       last_err = 1'b0, tx_en_prev = 1'b0;
    logic [7:0] cur_byte = 8'h00;
    int         n_checks = 0, n_errors = 0;

    // UART transmitter model plus bus monitor, sampled mid-cycle
    always @(negedge sys_clk) begin
        cyc++;
        if (!sys_rst_n) begin
            countdown  = 0;
            tx_done    = 1'b0;
            tx_en_prev = 1'b0;
            low_run    = 1000;
        end else begin
            tx_done = 1'b0;
            if (countdown > 0) begin
                countdown--;
                if (countdown == 0) begin
                    tx_done    = 1'b1;
                    cyc_txdone = cyc;
                end
            end
            if (tx_en && !tx_en_prev) begin
                if (low_run < min_low) min_low = low_run;
                if (byte_q.size() != withhold_idx) countdown = DLY;
                byte_q.push_back(tx_data);
                cur_byte = tx_data;
                cyc_rise = cyc;
            end
            if (tx_en && tx_data != cur_byte) unstable++;
            low_run    = tx_en ? 0 : low_run + 1;
            tx_en_prev = tx_en;
            if (rd_en) addr_q.push_back(rd_addr);
            if (done) begin
                done_cnt++;
                last_err = err;
                cyc_done = cyc;
            end
        end
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic check_reset_outputs(input string tag);
        check({tag, "_busy"}, busy, 0);
        check({tag, "_done"}, done, 0);
        check({tag, "_err"}, err, 0);
        check({tag, "_rd_en"}, rd_en, 0);
        check({tag, "_rd_addr"}, rd_addr, 0);
        check({tag, "_tx_en"}, tx_en, 0);
        check({tag, "_tx_data"}, tx_data, 0);
    endtask

    task automatic build_exp(input logic [7:0] b, input logic [7:0] l);
        logic [7:0] s, a;
        exp_q.delete();
        exp_q.push_back(8'hAA);
        exp_q.push_back(8'h55);
        exp_q.push_back(l);
        s = l;
        for (int i = 0; i < int'(l); i++) begin
            a = b + 8'(i);
            exp_q.push_back(mem[a]);
            s = s + mem[a];
        end
`ifdef FRAME_CSUM_EN
        exp_q.push_back(s);
`endif
    endtask

    task automatic check_bytes(input string tag, input int b0, input int n_exp);
        check({tag, "_byte_count"}, byte_q.size() - b0, n_exp);
        for (int i = 0; i < n_exp && i < byte_q.size() - b0; i++)
            check({tag, "_byte"}, byte_q[b0 + i], exp_q[i]);
    endtask

    task automatic run_frame(input logic [7:0] b, input logic [7:0] l, input bit mid, input bit on_done,
                             input int bound);
        int  b0, d0, n;
        bit  mid_done;
        b0 = byte_q.size();
        d0 = done_cnt;
        mid_done = 1'b0;
        n = 0;
        base_addr = b;
        frame_len = l;
        start = 1'b1;
        @(negedge sys_clk); #1;
        start = 1'b0;
        base_addr = 8'h33;
        frame_len = 8'h77;
        while (done_cnt == d0 && n < bound) begin
            @(negedge sys_clk); #1;
            n++;
            start = mid && !mid_done && (byte_q.size() == b0 + 4);
            if (start) mid_done = 1'b1;
        end
        check("frame_done_seen", done_cnt != d0, 1);
        if (on_done) begin
            start = 1'b1;
            @(negedge sys_clk); #1;
            start = 1'b0;
        end
        repeat (20) @(negedge sys_clk);
        #1;
    endtask

    initial begin
        int b0, a0, d0, n;
        for (int i = 0; i < 256; i++) mem[i] = 8'(i * 7 + 3);
        mem[0] = 8'h01; mem[1] = 8'h02; mem[2] = 8'h03;
        mem[8'hFE] = 8'hC8; mem[8'hFF] = 8'h4B;

        repeat (3) @(negedge sys_clk);
        #1;
        check_reset_outputs("reset");
        sys_rst_n = 1'b1;
        repeat (2) @(negedge sys_clk);
        #1;

        // T1: three payload bytes
        b0 = byte_q.size(); a0 = addr_q.size(); d0 = done_cnt;
        build_exp(8'h00, 8'd3);
        run_frame(8'h00, 8'd3, 1'b0, 1'b0, 2000);
        check_bytes("t1", b0, exp_q.size());
`ifdef FRAME_CSUM_EN
        check("t1_csum", byte_q[b0 + 6], 8'h09);
`endif
        check("t1_done_cnt", done_cnt - d0, 1);
        check("t1_err", last_err, 0);
        check("t1_rd_cnt", addr_q.size() - a0, 3);
        check("t1_addr0", addr_q[a0], 8'h00);
        check("t1_addr1", addr_q[a0 + 1], 8'h01);
        check("t1_addr2", addr_q[a0 + 2], 8'h02);
        check("t1_done_latency", cyc_done - cyc_txdone, GAP + 1);
        check("t1_busy_after", busy, 0);

        // T2: empty payload
        b0 = byte_q.size(); a0 = addr_q.size(); d0 = done_cnt;
        build_exp(8'h00, 8'd0);
        run_frame(8'h40, 8'd0, 1'b0, 1'b0, 2000);
        check_bytes("t2", b0, exp_q.size());
        check("t2_rd_cnt", addr_q.size() - a0, 0);
        check("t2_err", last_err, 0);

        // T3: address wrap
        b0 = byte_q.size(); a0 = addr_q.size();
        build_exp(8'hFE, 8'd4);
        run_frame(8'hFE, 8'd4, 1'b0, 1'b0, 2000);
        check_bytes("t3", b0, exp_q.size());
        check("t3_rd_cnt", addr_q.size() - a0, 4);
        check("t3_addr0", addr_q[a0], 8'hFE);
        check("t3_addr1", addr_q[a0 + 1], 8'hFF);
        check("t3_addr2", addr_q[a0 + 2], 8'h00);
        check("t3_addr3", addr_q[a0 + 3], 8'h01);
        check("t3_err", last_err, 0);

        // T4: transmitter never finishes the third byte
        b0 = byte_q.size(); d0 = done_cnt;
        withhold_idx = b0 + 2;
        build_exp(8'h00, 8'd3);
        run_frame(8'h00, 8'd3, 1'b0, 1'b0, 2000);
        check("t4_err", last_err, 1);
        check("t4_done_cnt", done_cnt - d0, 1);
        check("t4_tmo_window", (cyc_done - cyc_rise >= TMO - 2) && (cyc_done - cyc_rise <= TMO + 2), 1);
        repeat (100) @(negedge sys_clk);
        #1;
        check_bytes("t4", b0, 3);
        check("t4_tx_en_low", tx_en, 0);
        check("t4_busy_after", busy, 0);
        withhold_idx = -1;

        // T5: start mid-frame and start during done are both dropped
        b0 = byte_q.size(); d0 = done_cnt;
        build_exp(8'h20, 8'd2);
        run_frame(8'h20, 8'd2, 1'b1, 1'b1, 2000);
        repeat (100) @(negedge sys_clk);
        #1;
        check_bytes("t5", b0, exp_q.size());
        check("t5_done_cnt", done_cnt - d0, 1);
        check("t5_busy_after", busy, 0);

        // T6: reset in the payload, then a clean frame
        a0 = addr_q.size();
        base_addr = 8'h10; frame_len = 8'd5; start = 1'b1;
        @(negedge sys_clk); #1;
        start = 1'b0;
        n = 0;
        while (addr_q.size() < a0 + 2 && n < 1000) begin
            @(negedge sys_clk); #1;
            n++;
        end
        check("t6_reached_payload", addr_q.size() >= a0 + 2, 1);
        sys_rst_n = 1'b0;
        #1;
        check_reset_outputs("t6_reset");
        repeat (2) @(negedge sys_clk);
        sys_rst_n = 1'b1;
        repeat (2) @(negedge sys_clk);
        #1;
        b0 = byte_q.size(); d0 = done_cnt;
        build_exp(8'h00, 8'd3);
        run_frame(8'h00, 8'd3, 1'b0, 1'b0, 2000);
        check_bytes("t6", b0, exp_q.size());
        check("t6_err", last_err, 0);
        check("t6_done_cnt", done_cnt - d0, 1);

        check("tx_data_stable", unstable, 0);
        check("min_gap_ok", min_low >= GAP, 1);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end
endmodule
